// File: rtl/remap_pkg.sv
`default_nettype none
// ============================================================================
// Module  : remap_pkg
// Purpose : Shared op-codes, FSM state encoding and pointer-width helper for
//           the channel-index remap table.
// Revision: 1.0  initial release
// ============================================================================
package remap_pkg;

    localparam logic [1:0] OP_WRITE     = 2'd0;
    localparam logic [1:0] OP_READ      = 2'd1;
    localparam logic [1:0] OP_CLR_ZERO  = 2'd2;
    localparam logic [1:0] OP_CLR_IDENT = 2'd3;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] CLEAR    = 2'd1;
    localparam logic [1:0] INIT_CLR = 2'd2;

    // Clear pointer width; a single-entry table still needs one pointer bit.
    function automatic int clr_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/remap_lut_mem.sv
`default_nettype none
// ============================================================================
// Module  : remap_lut_mem
// Purpose : DEPTH x DATA_W table, one write port, NUM_PORTS registered
//           read-first read ports.
// Revision: 1.0  initial release
// ============================================================================
module remap_lut_mem
    import remap_pkg::*;
#(
    parameter int DEPTH     = 128,
    parameter int DATA_W    = 7,
    parameter int ADDR_W    = clr_ptr_w(DEPTH),
    parameter int NUM_PORTS = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        we,
    input  logic [ADDR_W-1:0]           waddr,
    input  logic [DATA_W-1:0]           wdata,
    input  logic [NUM_PORTS-1:0]        rd_en,
    input  logic [NUM_PORTS*ADDR_W-1:0] rd_addr,
    output logic [NUM_PORTS*DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Non-blocking read alongside the write gives old data on a collision.
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rd
        logic [DATA_W-1:0] r_q;

        always_ff @(posedge clk) begin
            if (reset) begin
                r_q <= '0;
            end else if (rd_en[p]) begin
                r_q <= r_mem[rd_addr[p*ADDR_W +: ADDR_W]];
            end
        end

        assign rd_data[p*DATA_W +: DATA_W] = r_q;
    end

endmodule
`default_nettype wire

// File: rtl/remap_lut_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : remap_lut_ctrl
// Purpose : Host-programmable channel remap table with sequenced clears and
//           NUM_RD parallel registered lookup ports.
// Revision: 1.0  initial release
// ============================================================================
module remap_lut_ctrl
    import remap_pkg::*;
#(
    parameter int IDX_W         = 7,
    parameter int DATA_W        = 7,
    parameter int DEPTH         = 128,
    parameter int NUM_RD        = 2,
    parameter bit INIT_IDENTITY = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_op,
    input  logic [IDX_W-1:0]         cmd_addr,
    input  logic [DATA_W-1:0]        cmd_data,
    output logic                     rsp_valid,
    output logic [DATA_W-1:0]        rsp_data,
    output logic                     busy,
    output logic                     err_oob,
    input  logic [NUM_RD-1:0]        lk_valid,
    input  logic [NUM_RD*IDX_W-1:0]  lk_idx,
    output logic [NUM_RD-1:0]        lk_out_valid,
    output logic [NUM_RD*DATA_W-1:0] lk_out
);

    localparam int               c_PTR_W     = clr_ptr_w(DEPTH);
    localparam logic [IDX_W:0]   c_DEPTH_EXT = (IDX_W+1)'(DEPTH);
    localparam logic [c_PTR_W-1:0] c_LAST_PTR = c_PTR_W'(DEPTH - 1);

    logic [1:0]          r_state;
    logic [c_PTR_W-1:0]  r_ptr;
    logic                r_fill_ident;
    logic                r_rsp_valid;
    logic                r_rsp_oob;
    logic                r_err_oob;
    logic [NUM_RD-1:0]   r_lk_valid;
    logic [NUM_RD-1:0]   r_lk_oob;

    logic                       w_accept;
    logic                       w_cmd_oob;
    logic                       w_rd_cmd;
    logic [c_PTR_W-1:0]         w_cmd_addr;
    logic [NUM_RD-1:0]          w_lk_oob;
    logic [NUM_RD*c_PTR_W-1:0]  w_lk_addr;
    logic                       w_we;
    logic [c_PTR_W-1:0]         w_waddr;
    logic [DATA_W-1:0]          w_wdata;
    logic [(NUM_RD+1)*DATA_W-1:0] w_rd_data;

    assign cmd_ready = (r_state == IDLE) && !reset;
    assign busy      = (r_state != IDLE) || reset;
    assign w_accept  = cmd_valid && cmd_ready;
    assign w_cmd_oob = {1'b0, cmd_addr} >= c_DEPTH_EXT;
    assign w_rd_cmd  = w_accept && (cmd_op == OP_READ);

    // Out-of-range addresses are steered to entry 0 and the result masked.
    assign w_cmd_addr = w_cmd_oob ? '0 : cmd_addr[c_PTR_W-1:0];

    for (genvar p = 0; p < NUM_RD; p++) begin : g_lk
        logic [IDX_W-1:0] w_idx;
        assign w_idx       = lk_idx[p*IDX_W +: IDX_W];
        assign w_lk_oob[p] = {1'b0, w_idx} >= c_DEPTH_EXT;
        assign w_lk_addr[p*c_PTR_W +: c_PTR_W] = w_lk_oob[p] ? '0 : w_idx[c_PTR_W-1:0];
        assign lk_out[p*DATA_W +: DATA_W] = r_lk_oob[p] ? '0 : w_rd_data[p*DATA_W +: DATA_W];
    end

    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_ptr;
        w_wdata = '0;
        if (!reset) begin
            if (r_state != IDLE) begin
                w_we    = 1'b1;
                w_wdata = r_fill_ident ? DATA_W'(r_ptr) : '0;
            end else if (w_accept && (cmd_op == OP_WRITE) && !w_cmd_oob) begin
                w_we    = 1'b1;
                w_waddr = w_cmd_addr;
                w_wdata = cmd_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= INIT_CLR;
            r_ptr        <= '0;
            r_fill_ident <= INIT_IDENTITY;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept && (cmd_op == OP_CLR_ZERO || cmd_op == OP_CLR_IDENT)) begin
                        r_state      <= CLEAR;
                        r_ptr        <= '0;
                        r_fill_ident <= (cmd_op == OP_CLR_IDENT);
                    end
                end
                CLEAR, INIT_CLR: begin
                    if (r_ptr == c_LAST_PTR) begin
                        r_state <= IDLE;
                    end else begin
                        r_ptr <= r_ptr + 1'b1;
                    end
                end
                default: begin
                    r_state <= INIT_CLR;
                    r_ptr   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_oob   <= 1'b0;
            r_err_oob   <= 1'b0;
            r_lk_valid  <= '0;
            r_lk_oob    <= '0;
        end else begin
            r_rsp_valid <= w_rd_cmd;
            if (w_rd_cmd) begin
                r_rsp_oob <= w_cmd_oob;
            end
            if (w_accept && (cmd_op == OP_WRITE || cmd_op == OP_READ) && w_cmd_oob) begin
                r_err_oob <= 1'b1;
            end
            r_lk_valid <= lk_valid;
            for (int p = 0; p < NUM_RD; p++) begin
                if (lk_valid[p]) begin
                    r_lk_oob[p] <= w_lk_oob[p];
                end
            end
        end
    end

    assign rsp_valid    = r_rsp_valid;
    assign rsp_data     = r_rsp_oob ? '0 : w_rd_data[NUM_RD*DATA_W +: DATA_W];
    assign err_oob      = r_err_oob;
    assign lk_out_valid = r_lk_valid;

    // Port NUM_RD serves host READs; ports 0..NUM_RD-1 serve lookups.
    remap_lut_mem #(
        .DEPTH     (DEPTH),
        .DATA_W    (DATA_W),
        .ADDR_W    (c_PTR_W),
        .NUM_PORTS (NUM_RD + 1)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .we      (w_we),
        .waddr   (w_waddr),
        .wdata   (w_wdata),
        .rd_en   ({w_rd_cmd, lk_valid}),
        .rd_addr ({w_cmd_addr, w_lk_addr}),
        .rd_data (w_rd_data)
    );

endmodule
`default_nettype wire

// File: tb/tb_remap_lut_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_remap_lut_ctrl
// Purpose : Scoreboard bench for remap_lut_ctrl (DEPTH=128 and DEPTH=100).
// Revision: 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_remap_lut_ctrl;
    import remap_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // DUT A: DEPTH=128
    logic        cmd_valid, cmd_ready, rsp_valid, busy, err_oob;
    logic [1:0]  cmd_op;
    logic [6:0]  cmd_addr, cmd_data, rsp_data;
    logic [1:0]  lk_valid, lk_out_valid;
    logic [13:0] lk_idx, lk_out;

    // DUT B: DEPTH=100
    logic        b_cmd_valid, b_cmd_ready, b_rsp_valid, b_busy, b_err_oob;
    logic [1:0]  b_cmd_op;
    logic [6:0]  b_cmd_addr, b_cmd_data, b_rsp_data;
    logic [1:0]  b_lk_valid, b_lk_out_valid;
    logic [13:0] b_lk_idx, b_lk_out;

    remap_lut_ctrl #(.IDX_W(7), .DATA_W(7), .DEPTH(128), .NUM_RD(2), .INIT_IDENTITY(1'b1)) u_dut_a (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy), .err_oob(err_oob),
        .lk_valid(lk_valid), .lk_idx(lk_idx), .lk_out_valid(lk_out_valid), .lk_out(lk_out)
    );

    remap_lut_ctrl #(.IDX_W(7), .DATA_W(7), .DEPTH(100), .NUM_RD(2), .INIT_IDENTITY(1'b1)) u_dut_b (
        .clk(clk), .reset(reset), .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
        .cmd_op(b_cmd_op), .cmd_addr(b_cmd_addr), .cmd_data(b_cmd_data),
        .rsp_valid(b_rsp_valid), .rsp_data(b_rsp_data), .busy(b_busy), .err_oob(b_err_oob),
        .lk_valid(b_lk_valid), .lk_idx(b_lk_idx), .lk_out_valid(b_lk_out_valid), .lk_out(b_lk_out)
    );

    int n_pass  = 0;
    int n_total = 0;

    logic [6:0] a_rsp_q[$];
    logic [6:0] a_lk0_q[$];
    logic [6:0] a_lk1_q[$];
    logic [6:0] b_rsp_q[$];
    logic [6:0] b_lk0_q[$];

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic fail_now(input string name);
        n_total++;
        $display("FAIL %s: unexpected event (cycle %0d)", name, cyc);
    endtask

    // Monitor: every presented response is matched against the scoreboard.
    always @(negedge clk) begin
        if (rsp_valid) begin
            if (a_rsp_q.size() == 0) fail_now("a_rsp_unexpected");
            else chk("a_rsp_data", int'(rsp_data), int'(a_rsp_q.pop_front()));
        end
        if (lk_out_valid[0]) begin
            if (a_lk0_q.size() == 0) fail_now("a_lk0_unexpected");
            else chk("a_lk0_data", int'(lk_out[6:0]), int'(a_lk0_q.pop_front()));
        end
        if (lk_out_valid[1]) begin
            if (a_lk1_q.size() == 0) fail_now("a_lk1_unexpected");
            else chk("a_lk1_data", int'(lk_out[13:7]), int'(a_lk1_q.pop_front()));
        end
        if (b_rsp_valid) begin
            if (b_rsp_q.size() == 0) fail_now("b_rsp_unexpected");
            else chk("b_rsp_data", int'(b_rsp_data), int'(b_rsp_q.pop_front()));
        end
        if (b_lk_out_valid[0]) begin
            if (b_lk0_q.size() == 0) fail_now("b_lk0_unexpected");
            else chk("b_lk0_data", int'(b_lk_out[6:0]), int'(b_lk0_q.pop_front()));
        end
        if (b_lk_out_valid[1]) fail_now("b_lk1_unexpected");
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    // Hold a command valid until accepted; acc is the accepting edge number.
    task automatic issue(input logic [1:0] op, input int addr, input int data,
                         input int exp, output int acc);
        acc = -1;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = 7'(addr);
        cmd_data  = 7'(data);
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (cmd_ready) begin
                if (op == OP_READ) a_rsp_q.push_back(7'(exp));
                acc = cyc + 1;
                break;
            end
            @(posedge clk); #1;
        end
        if (acc < 0) fail_now("cmd_accept_timeout");
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic lookup_a(input logic [1:0] v, input int i0, input int i1,
                            input int e0, input int e1);
        if (v[0]) a_lk0_q.push_back(7'(e0));
        if (v[1]) a_lk1_q.push_back(7'(e1));
        lk_valid = v;
        lk_idx   = {7'(i1), 7'(i0)};
        step();
        lk_valid = 2'b00;
    endtask

    task automatic b_cmd(input logic [1:0] op, input int addr, input int data, input int exp);
        b_cmd_valid = 1'b1;
        b_cmd_op    = op;
        b_cmd_addr  = 7'(addr);
        b_cmd_data  = 7'(data);
        @(negedge clk);
        chk("b_cmd_ready", int'(b_cmd_ready), 1);
        if (op == OP_READ) b_rsp_q.push_back(7'(exp));
        step();
        b_cmd_valid = 1'b0;
    endtask

    task automatic b_lookup(input int idx, input int exp);
        b_lk0_q.push_back(7'(exp));
        b_lk_valid = 2'b01;
        b_lk_idx   = {7'd0, 7'(idx)};
        step();
        b_lk_valid = 2'b00;
    endtask

    // Count busy cycles of A after reset release; note where B goes idle.
    task automatic count_busy(output int na, output int nb);
        na = 0;
        nb = -1;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (nb < 0 && !b_busy) nb = na;
            if (!busy) break;
            na++;
        end
        step();
    endtask

    initial begin
        int na, nb, t_clr, t_wr, acc;
        cmd_valid = 1'b0; cmd_op = 2'd0; cmd_addr = '0; cmd_data = '0;
        lk_valid = '0; lk_idx = '0;
        b_cmd_valid = 1'b0; b_cmd_op = 2'd0; b_cmd_addr = '0; b_cmd_data = '0;
        b_lk_valid = '0; b_lk_idx = '0;

        repeat (3) step();
        @(negedge clk);
        chk("rst_busy", int'(busy), 1);
        chk("rst_cmd_ready", int'(cmd_ready), 0);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_rsp_data", int'(rsp_data), 0);
        chk("rst_lk_out_valid", int'(lk_out_valid), 0);
        chk("rst_lk_out", int'(lk_out), 0);
        chk("rst_err_oob", int'(err_oob), 0);
        step();
        reset = 1'b0;

        count_busy(na, nb);
        chk("init_busy_cycles_a", na, 128);
        chk("init_busy_cycles_b", nb, 100);

        // Identity fill after reset
        issue(OP_READ, 37, 0, 37, acc);

        // Write then dual-port lookup
        issue(OP_WRITE, 5, 'h2A, 0, acc);
        lookup_a(2'b11, 5, 6, 'h2A, 6);
        step();
        @(negedge clk);
        chk("lk_hold_value", int'(lk_out), int'({7'd6, 7'h2A}));
        chk("lk_hold_valid_low", int'(lk_out_valid), 0);
        step();

        // Both ports on the same index
        lookup_a(2'b11, 37, 37, 37, 37);

        // Collision: lookup of entry 9 during write to entry 9 sees old value
        a_lk0_q.push_back(7'd9);
        lk_valid = 2'b01; lk_idx = {7'd0, 7'd9};
        cmd_valid = 1'b1; cmd_op = OP_WRITE; cmd_addr = 7'd9; cmd_data = 7'h11;
        @(negedge clk);
        chk("coll_cmd_ready", int'(cmd_ready), 1);
        step();
        cmd_valid = 1'b0; lk_valid = 2'b00;
        lookup_a(2'b01, 9, 0, 'h11, 0);

        // CLR_ZERO with traffic
        issue(OP_CLR_ZERO, 0, 0, 0, t_clr);
        @(negedge clk);
        chk("clr_busy", int'(busy), 1);
        chk("clr_cmd_ready", int'(cmd_ready), 0);
        step();
        repeat (48) step();
        lookup_a(2'b01, 100, 0, 100, 0);
        repeat (9) step();
        issue(OP_WRITE, 3, 'h55, 0, t_wr);
        chk("clr_write_accept_delay", t_wr - t_clr, 129);
        issue(OP_READ, 0, 0, 0, acc);
        issue(OP_READ, 3, 0, 'h55, acc);
        issue(OP_READ, 100, 0, 0, acc);
        issue(OP_READ, 127, 0, 0, acc);

        // Out-of-range on the DEPTH=100 instance
        b_lookup(99, 99);
        b_lookup(110, 0);
        @(negedge clk);
        chk("b_err_after_lk_oob", int'(b_err_oob), 0);
        step();
        b_cmd(OP_WRITE, 120, 'h7F, 0);
        b_cmd(OP_READ, 120, 0, 0);
        b_cmd(OP_READ, 20, 0, 20);
        @(negedge clk);
        chk("b_err_set", int'(b_err_oob), 1);
        step();
        b_cmd(OP_CLR_ZERO, 120, 0, 0);
        repeat (105) step();
        b_cmd(OP_READ, 20, 0, 0);
        @(negedge clk);
        chk("b_err_sticky", int'(b_err_oob), 1);
        step();

        // Reset in the middle of a clear
        issue(OP_CLR_ZERO, 0, 0, 0, t_clr);
        repeat (29) step();
        reset = 1'b1;
        step();
        @(negedge clk);
        chk("midrst_busy", int'(busy), 1);
        chk("midrst_cmd_ready", int'(cmd_ready), 0);
        chk("midrst_lk_out", int'(lk_out), 0);
        chk("midrst_b_err_cleared", int'(b_err_oob), 0);
        step();
        reset = 1'b0;
        count_busy(na, nb);
        chk("midrst_busy_cycles_a", na, 128);
        chk("midrst_busy_cycles_b", nb, 100);
        issue(OP_READ, 127, 0, 127, acc);
        issue(OP_READ, 10, 0, 10, acc);
        issue(OP_READ, 5, 0, 5, acc);

        repeat (4) step();
        chk("a_rsp_q_drained", a_rsp_q.size(), 0);
        chk("a_lk0_q_drained", a_lk0_q.size(), 0);
        chk("a_lk1_q_drained", a_lk1_q.size(), 0);
        chk("b_rsp_q_drained", b_rsp_q.size(), 0);
        chk("b_lk0_q_drained", b_lk0_q.size(), 0);
        chk("b_lk1_idle_value", int'(b_lk_out[13:7]), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
